// File: rtl/s_axi_lite_regbank.sv
`timescale 1ns/1ps
// Purpose: AXI4-Lite slave CSR bank. RW registers are exported on reg_out; RO registers are read live from reg_in.
// Latency: write response one edge after AW and W are both held; read data one edge after the AR handshake.
// Backpressure: one write and one read in flight; AW/W readies stay low until B is taken; AR stays low until R is taken.
// Ports: s_axi_* AXI4-Lite slave (clock s_axi_clk, async active-low s_axi_resetn);
//        reg_out/reg_in flat per-register vectors (register i at [i*DATA_WIDTH +: DATA_WIDTH]);
//        reg_wr_stb one-cycle pulse per register on each successful write commit.
module s_axi_lite_regbank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           s_axi_clk,
    input  logic                           s_axi_resetn,
    input  logic                           s_axi_awvalid,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    output logic                           s_axi_awready,
    input  logic                           s_axi_wvalid,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    output logic                           s_axi_wready,
    output logic                           s_axi_bvalid,
    output logic [1:0]                     s_axi_bresp,
    input  logic                           s_axi_bready,
    input  logic                           s_axi_arvalid,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    output logic                           s_axi_arready,
    output logic                           s_axi_rvalid,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);

    logic                           ready_en;
    logic                           aw_held;
    logic                           w_held;
    logic [ADDR_WIDTH-1:0]          aw_addr;
    logic [DATA_WIDTH-1:0]          w_data;
    logic [NBYTES-1:0]              w_strb;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;
    logic                           bvalid_q;
    logic [1:0]                     bresp_q;
    logic                           rvalid_q;
    logic [1:0]                     rresp_q;
    logic [DATA_WIDTH-1:0]          rdata_q;
    logic [NUM_REGS-1:0]            wr_stb_q;

    logic                           aw_hs, w_hs, b_hs, ar_hs, r_hs, do_commit;
    logic [NUM_REGS-1:0]            wr_hit, rd_hit;
    logic                           wr_err, rd_err;
    logic [DATA_WIDTH-1:0]          rd_val;

    function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) >> LSB;
    endfunction

    assign s_axi_awready = ready_en & ~aw_held & ~bvalid_q;
    assign s_axi_wready  = ready_en & ~w_held & ~bvalid_q;
    assign s_axi_arready = ready_en & ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign reg_wr_stb    = wr_stb_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign b_hs  = bvalid_q & s_axi_bready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = rvalid_q & s_axi_rready;

    // Both halves held and no response pending; bvalid blocks a second commit
    // of the same transaction while waiting for bready.
    assign do_commit = aw_held & w_held & ~bvalid_q;

    // One-hot decode. An address below BASE_ADDR or past the last register
    // hits nothing, so "no hit" is exactly the decode-error condition.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (aw_addr >= BASE_ADDR) && (word_idx(aw_addr) == ADDR_WIDTH'(i));
            rd_hit[i] = (s_axi_araddr >= BASE_ADDR) && (word_idx(s_axi_araddr) == ADDR_WIDTH'(i));
        end
    end

    assign wr_err = ~|(wr_hit & ~RO_MASK);
    assign rd_err = ~|rd_hit;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit[i]) begin
                rd_val = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH]
                                    : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            regs_q   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
            wr_stb_q <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_stb_q <= '0;

            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end

            if (do_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? 2'b10 : 2'b00;
                // Strobe fires on a good commit even with all byte enables low.
                wr_stb_q <= wr_hit & ~RO_MASK;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_hit[i] && !RO_MASK[i]) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (w_strb[b]) begin
                                regs_q[i*DATA_WIDTH + b*8 +: 8] <= w_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end

            // Reads see regs_q before any same-edge write commit lands.
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_err ? 2'b10 : 2'b00;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // RO slots export zero; their storage is never written.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[g] ? '0 : regs_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: doc/s_axi_lite_regbank.md
Name: s_axi_lite_regbank

Overview:
Generalised AXI4-Lite slave register bank for control/status register blocks (GPIO, timers, etc.). It has a parametrised data width, register count, base address and per-register read-only mask. Unlike the earlier slave, AW and W may arrive in either order or together. RO registers are sourced live from hardware inputs, and all RW registers are exported flat to fabric logic with per-register write strobes. One write and one read may be outstanding concurrently.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
ADDR_WIDTH, 32, AXI byte-address width.
NUM_REGS, 16, number of registers; 1..256.
BASE_ADDR, 0, byte base address of register 0; aligned to DATA_WIDTH/8.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (value from reg_in).

Ports:
s_axi_clk  in  1  clock
s_axi_resetn  in  1  asynchronous active-low reset
s_axi_awvalid  in  1  write address valid
s_axi_awaddr  in  ADDR_WIDTH  write byte address
s_axi_awready  out  1  write address ready
s_axi_wvalid  in  1  write data valid
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_wready  out  1  write data ready
s_axi_bvalid  out  1  write response valid
s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axi_bready  in  1  write response ready
s_axi_arvalid  in  1  read address valid
s_axi_araddr  in  ADDR_WIDTH  read byte address
s_axi_arready  out  1  read address ready
s_axi_rvalid  out  1  read data valid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rready  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]; RO slots drive 0
reg_in  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers; RW slots ignored
reg_wr_stb  out  NUM_REGS  one-cycle pulse when register i is committed by a successful write

Behaviour:
- Reset is asynchronous, active-low, on s_axi_clk. While asserted, every output is 0: all readies, bvalid, bresp, rvalid, rresp, rdata, reg_out, reg_wr_stb. Held AW/W flags and all RW registers are also 0.
- Ready enable: an internal flop ready_en sets to 1 on the first clock edge after reset deassertion. No ready asserts before it.
- Decode: word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low address bits are ignored.
- Decode error: the address is in error if addr < BASE_ADDR or index >= NUM_REGS.
- Write error: also an error if the target register is RO.
- Write channel readies: awready = ready_en & !aw_held & !bvalid; wready = ready_en & !w_held & !bvalid.
- Write capture: an AW handshake latches the address and sets aw_held; a W handshake latches data/strobe and sets w_held. Either order, or the same cycle.
- Write commit: on the first edge where the held address and held data are both present (both flags set, or either completing by handshake that cycle), the next edge performs the commit.
  - Byte lanes with wstrb=1 are written unless in error.
  - reg_wr_stb[index] pulses for one cycle if no error, even when wstrb=0.
  - bvalid goes high; bresp = 10 on error, else 00.
  - Latency: AW+W same-cycle handshake at edge N gives bvalid=1 after edge N+1.
- Write response: bvalid and bresp hold until bready. The B handshake edge clears bvalid, aw_held and w_held; awready/wready rise in the following cycle.
- Write backpressure: a second AW or W is never accepted while the first transaction is unfinished.
- Read channel: arready = ready_en & !rvalid. The AR handshake at edge N registers rdata/rresp, and rvalid=1 after edge N.
  - RW register: rdata is the register content.
  - RO register: rdata is reg_in sampled at edge N.
  - Error: rdata=0, rresp=10.
- Read response: rdata, rresp and rvalid hold until rready. The R handshake edge clears rvalid; arready reasserts the next cycle.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- Reset mid-transaction: any pending write or read is discarded. No register update and no response occur after reset release.

Test Plan:
1. Reset release, then AW(0x04)+W(0xDEADBEEF, wstrb=F) in the same cycle, bready=1 -> bresp=00 one edge later; reg_wr_stb[1] pulses once; reg_out[63:32]=0xDEADBEEF; read 0x04 returns 0xDEADBEEF with rresp=00.
2. W(0x0000AA55, wstrb=0011) three cycles before AW(0x08) -> wready drops after the W handshake; awready is accepted later; reg 2 becomes 0x0000AA55 with upper bytes unchanged; bresp=00.
3. RO_MASK bit 3 set, reg_in slot3=0x12345678: write 0x0C -> bresp=10, no strobe, no change. Read 0x0C -> 0x12345678; change reg_in, read again -> the new value.
4. NUM_REGS=16: write and read 0x40 -> bresp=10; rresp=10 with rdata=0; no reg_out change. With BASE_ADDR=0x100, address 0x0FC -> SLVERR.
5. Hold bready=0 for 10 cycles after a write -> bvalid stays 1 with constant bresp. awready and wready stay 0 while a concurrent read to another register completes normally.
6. Assert reset while aw_held=1 and W not yet sent -> all outputs 0 immediately. After release, a send of W alone produces no bvalid until a new AW arrives.
